bcd_updown_counter: RTL and testbench



---
 rtl/bcd_updown_counter.sv | 59 +++++
 tb/tb_bcd_updown_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// Three-digit BCD up/down counter (000-999) with wrap-around in both directions.
// Each digit is a mod-10 up/down cell; carry/borrow ripples combinationally.
module bcd_updown_counter (
    input  logic       CE,
    input  logic       RESET,
    input  logic       REVERSE,
    output logic [3:0] CNT1,
    output logic [3:0] CNT2,
    output logic [3:0] CNT3
);

    logic [3:0] cnt1_r, cnt2_r, cnt3_r;
    logic [3:0] nxt1_s, nxt2_s, nxt3_s;
    logic       c1_s, c2_s, c3_s;

    // Mod-10 cell: returns {carry/borrow out, next digit}. Non-BCD contents reload 0.
    function automatic logic [4:0] digit_step(input logic [3:0] d,
                                              input logic       rev,
                                              input logic       cin);
        logic [4:0] r;
        if (d > 4'd9) begin
            r = {1'b0, 4'd0};
        end else if (!cin) begin
            r = {1'b0, d};
        end else if (!rev) begin
            if (d == 4'd9) r = {1'b1, 4'd0};
            else           r = {1'b0, d + 4'd1};
        end else begin
            if (d == 4'd0) r = {1'b1, 4'd9};
            else           r = {1'b0, d - 4'd1};
        end
        return r;
    endfunction

    // Chain of three cells; the units cell always steps.
    always_comb begin
        {c1_s, nxt1_s} = digit_step(cnt1_r, REVERSE, 1'b1);
        {c2_s, nxt2_s} = digit_step(cnt2_r, REVERSE, c1_s);
        {c3_s, nxt3_s} = digit_step(cnt3_r, REVERSE, c2_s);
    end

    // Digit registers; reset has priority over counting.
    always_ff @(posedge CE) begin
        if (RESET) begin
            cnt1_r <= 4'd0;
            cnt2_r <= 4'd0;
            cnt3_r <= 4'd0;
        end else begin
            cnt1_r <= nxt1_s;
            cnt2_r <= nxt2_s;
            cnt3_r <= nxt3_s;
        end
    end

    assign CNT1 = cnt1_r;
    assign CNT2 = cnt2_r;
    assign CNT3 = cnt3_r;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench: integer-valued model (mod-1000 arithmetic) compared every
// cycle, plus directed literal expectations from the test plan.
module tb_bcd_updown_counter;

    logic       ce;
    logic       reset;
    logic       reverse;
    logic [3:0] cnt1, cnt2, cnt3;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int mv        = 0;
    bit model_valid = 1'b0;

    bcd_updown_counter dut (
        .CE      (ce),
        .RESET   (reset),
        .REVERSE (reverse),
        .CNT1    (cnt1),
        .CNT2    (cnt2),
        .CNT3    (cnt3)
    );

    initial ce = 1'b0;
    always #10 ce = ~ce;

    function automatic int dut_val();
        return 100 * int'(cnt3) + 10 * int'(cnt2) + int'(cnt1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain modular arithmetic on the decimal value.
    always @(posedge ce) begin
        if (reset) begin
            mv = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            mv = reverse ? (mv + 999) % 1000 : (mv + 1) % 1000;
        end
    end

    // Per-cycle compare against the model, plus digit range.
    always @(negedge ce) begin
        if (model_valid) begin
            check("model", dut_val(), mv);
            check("digit_range", int'(cnt1 <= 4'd9 && cnt2 <= 4'd9 && cnt3 <= 4'd9), 1);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge ce);
            #1;
        end
    endtask

    initial begin
        reset   = 1'b1;
        reverse = 1'b0;
        @(negedge ce);
        tick(1);
        check("reset_000", dut_val(), 0);
        reset = 1'b0;
        tick(1);
        check("first_001", dut_val(), 1);
        tick(9);
        check("ten_010", dut_val(), 10);
        tick(508);
        check("up_518", dut_val(), 518);
        check("up_518_cnt3", int'(cnt3), 5);
        check("up_518_cnt2", int'(cnt2), 1);
        check("up_518_cnt1", int'(cnt1), 8);

        reverse = 1'b1;
        tick(518);
        check("down_000", dut_val(), 0);
        tick(1);
        check("down_wrap_999", dut_val(), 999);
        tick(6);
        check("down_end_993", dut_val(), 993);

        reverse = 1'b0;
        tick(5);
        check("up_998", dut_val(), 998);
        tick(1);
        check("up_999", dut_val(), 999);
        tick(1);
        check("up_wrap_000", dut_val(), 0);

        tick(100);
        check("at_100", dut_val(), 100);
        reverse = 1'b1;
        tick(1);
        check("rev_099", dut_val(), 99);
        reverse = 1'b0;
        tick(1);
        check("fwd_100", dut_val(), 100);

        tick(357);
        check("at_457", dut_val(), 457);
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            reverse = ~reverse;
            tick(1);
            check("reset_hold_000", dut_val(), 0);
        end
        reset   = 1'b0;
        reverse = 1'b1;
        tick(1);
        check("resume_down_999", dut_val(), 999);
        reverse = 1'b0;
        tick(1);
        check("resume_up_000", dut_val(), 0);

        @(negedge ce);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
